uart_tx_seq: RTL and testbench

UART_TX_SEQ -- requirements
Module: uart_tx_seq

---
 rtl/uart_tx_seq.sv | 103 ++++++++++
 tb/tb_uart_tx_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: UART frame transmitter (start, LSB-first data, optional parity, stop bits) paced by an external baud tick.
module uart_tx_seq #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 CLOCK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] TX_DATA,
   input  logic                 TX_VALID,
   output logic                 TX_READY,
   output logic                 BPS_EN,
   input  logic                 BPS_TICK,
   output logic                 TXD,
   output logic                 TX_BUSY,
   output logic                 TX_DONE
);
   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t state, state_nxt;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic par_q, par_nxt, txd_q, txd_nxt, done_q, done_nxt;
   always_ff @(posedge CLOCK) begin
      if (RST) begin
         state   <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shift_q <= shift_nxt;
         cnt_q   <= cnt_nxt;
         par_q   <= par_nxt;
         txd_q   <= txd_nxt;
         done_q  <= done_nxt;
      end
   end
   // TXD is registered from the next-state decode, so each level appears the cycle after its tick
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
      par_nxt   = par_q;
      txd_nxt   = txd_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            txd_nxt = 1'b1;
            if (TX_VALID) begin
               state_nxt = START;
               shift_nxt = TX_DATA;
               par_nxt   = (PARITY == 1) ? ~^TX_DATA : ^TX_DATA;
               txd_nxt   = 1'b0;
            end
         end
         START: if (BPS_TICK) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            txd_nxt   = shift_q[0];
            shift_nxt = shift_q >> 1;
         end
         DATA: if (BPS_TICK) begin
            if (cnt_q == LAST_DATA) begin
               cnt_nxt   = '0;
               state_nxt = (PARITY != 0) ? PAR : STOP;
               txd_nxt   = (PARITY != 0) ? par_q : 1'b1;
            end else begin
               cnt_nxt   = cnt_q + 1'b1;
               txd_nxt   = shift_q[0];
               shift_nxt = shift_q >> 1;
            end
         end
         PAR: if (BPS_TICK) begin
            state_nxt = STOP;
            cnt_nxt   = '0;
            txd_nxt   = 1'b1;
         end
         STOP: if (BPS_TICK) begin
            if (cnt_q == LAST_STOP) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt_q + 1'b1;
            end
            txd_nxt = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end
   assign TX_READY = (state == IDLE);
   assign BPS_EN   = (state != IDLE);
   assign TX_BUSY  = (state != IDLE);
   assign TX_DONE  = done_q;
   assign TXD      = txd_q;
endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: directed checks of uart_tx_seq framing, parity, stop bits, back-to-back and reset behaviour.
module tb_uart_tx_seq;
   logic clk, rst, tick;
   logic [7:0] d0, dp;
   logic [6:0] d3;
   logic v0, v1, v2, v3;
   logic rdy0, rdy1, rdy2, rdy3, en0, en1, en2, en3;
   logic txd0, txd1, txd2, txd3, busy0, busy1, busy2, busy3, done0, done1, done2, done3;
   logic txd_s, busy_s, en_s, rdy_s, done_s;
   logic keep, scramble;
   int sel, checks, errors, acc0, dn0, base;

   uart_tx_seq u0 (.CLOCK(clk), .RST(rst), .TX_DATA(d0), .TX_VALID(v0), .TX_READY(rdy0), .BPS_EN(en0),
                   .BPS_TICK(tick), .TXD(txd0), .TX_BUSY(busy0), .TX_DONE(done0));
   uart_tx_seq #(.PARITY(2)) u1 (.CLOCK(clk), .RST(rst), .TX_DATA(dp), .TX_VALID(v1), .TX_READY(rdy1), .BPS_EN(en1),
                   .BPS_TICK(tick), .TXD(txd1), .TX_BUSY(busy1), .TX_DONE(done1));
   uart_tx_seq #(.PARITY(1)) u2 (.CLOCK(clk), .RST(rst), .TX_DATA(dp), .TX_VALID(v2), .TX_READY(rdy2), .BPS_EN(en2),
                   .BPS_TICK(tick), .TXD(txd2), .TX_BUSY(busy2), .TX_DONE(done2));
   uart_tx_seq #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.CLOCK(clk), .RST(rst), .TX_DATA(d3), .TX_VALID(v3), .TX_READY(rdy3),
                   .BPS_EN(en3), .BPS_TICK(tick), .TXD(txd3), .TX_BUSY(busy3), .TX_DONE(done3));

   assign txd_s  = sel == 0 ? txd0  : sel == 1 ? txd1  : sel == 2 ? txd2  : txd3;
   assign busy_s = sel == 0 ? busy0 : sel == 1 ? busy1 : sel == 2 ? busy2 : busy3;
   assign en_s   = sel == 0 ? en0   : sel == 1 ? en1   : sel == 2 ? en2   : en3;
   assign rdy_s  = sel == 0 ? rdy0  : sel == 1 ? rdy1  : sel == 2 ? rdy2  : rdy3;
   assign done_s = sel == 0 ? done0 : sel == 1 ? done1 : sel == 2 ? done2 : done3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && v0 && rdy0) acc0 <= acc0 + 1;
      if (done0) dn0 <= dn0 + 1;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick_period(input logic exp, input int len, input string tag);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         chk({tag, "_txd"}, txd_s, exp);
         if (i == 0) begin
            chk({tag, "_busy"}, busy_s, 1'b1);
            chk({tag, "_en"}, en_s, 1'b1);
            chk({tag, "_rdy"}, rdy_s, 1'b0);
            chk({tag, "_done"}, done_s, 1'b0);
         end
         tick = (i == len - 1);
         if (scramble) d0 = 8'($urandom);
         if (!keep) begin
            v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input logic [11:0] bits, input int n, input int len, input string tag);
      for (int b = 0; b < n; b++) tick_period(bits[b], len, $sformatf("%s_b%0d", tag, b));
   endtask

   task automatic end_chk(input string tag);
      @(negedge clk);
      tick = 1'b0;
      chk({tag, "_done"}, done_s, 1'b1);
      chk({tag, "_txd"}, txd_s, 1'b1);
      chk({tag, "_rdy"}, rdy_s, 1'b1);
      chk({tag, "_en"}, en_s, 1'b0);
      chk({tag, "_busy"}, busy_s, 1'b0);
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk({tag, "_done0"}, done_s, 1'b0);
      chk({tag, "_txd1"}, txd_s, 1'b1);
      chk({tag, "_rdy1"}, rdy_s, 1'b1);
   endtask

   initial begin
      checks = 0; errors = 0; acc0 = 0; dn0 = 0; sel = 0;
      rst = 1'b1; tick = 1'b0; keep = 1'b0; scramble = 1'b0;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
      d0 = 8'h00; dp = 8'h00; d3 = 7'h00;
      repeat (2) @(negedge clk);
      chk("rst_txd", txd0, 1'b1);
      chk("rst_rdy", rdy0, 1'b1);
      chk("rst_en", en0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      rst = 1'b0;
      // 0x55 default framing, 16-cycle ticks
      @(negedge clk); v0 = 1'b1; d0 = 8'h55;
      send_frame(12'b0010_1010_1010, 10, 16, "f55");
      end_chk("f55_end");
      idle_chk("f55_idle");
      // ticks in IDLE are ignored
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         chk("idle_tick_txd", txd0, 1'b1);
         chk("idle_tick_rdy", rdy0, 1'b1);
         chk("idle_tick_en", en0, 1'b0);
      end
      // even and odd parity on 0xA3
      sel = 1;
      @(negedge clk); v1 = 1'b1; dp = 8'hA3;
      send_frame(12'b0101_0100_0110, 11, 3, "even");
      end_chk("even_end");
      idle_chk("even_idle");
      sel = 2;
      @(negedge clk); v2 = 1'b1; dp = 8'hA3;
      send_frame(12'b0111_0100_0110, 11, 3, "odd");
      end_chk("odd_end");
      idle_chk("odd_idle");
      // 7 data bits, 2 stop bits, data 0x35
      sel = 3;
      @(negedge clk); v3 = 1'b1; d3 = 7'h35;
      send_frame(12'b0011_0110_1010, 10, 3, "d7s2");
      end_chk("d7s2_end");
      idle_chk("d7s2_idle");
      // back-to-back with TX_VALID held and TX_DATA churning mid-frame
      sel = 0;
      base = acc0;
      @(negedge clk); v0 = 1'b1; d0 = 8'h01; keep = 1'b1; scramble = 1'b1;
      send_frame(12'b0010_0000_0010, 10, 4, "b2b1");
      end_chk("b2b1_end");
      d0 = 8'h80; keep = 1'b0;
      send_frame(12'b0011_0000_0000, 10, 4, "b2b2");
      scramble = 1'b0;
      end_chk("b2b2_end");
      idle_chk("b2b2_idle");
      chk_int("b2b_accepts", acc0 - base, 2);
      // reset and valid together must not accept
      @(negedge clk); rst = 1'b1; v0 = 1'b1; d0 = 8'h3C;
      @(negedge clk);
      chk("rstv_rdy", rdy0, 1'b1);
      chk("rstv_busy", busy0, 1'b0);
      rst = 1'b0; v0 = 1'b0;
      @(negedge clk);
      chk("rstv_busy2", busy0, 1'b0);
      chk("rstv_txd", txd0, 1'b1);
      // reset during data bit 3 aborts without TX_DONE
      base = dn0;
      @(negedge clk); v0 = 1'b1; d0 = 8'hA5;
      tick_period(1'b0, 4, "ab_st");
      tick_period(1'b1, 4, "ab_d0");
      tick_period(1'b0, 4, "ab_d1");
      tick_period(1'b1, 4, "ab_d2");
      @(negedge clk);
      chk("ab_d3_txd", txd0, 1'b0);
      tick = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("ab_txd", txd0, 1'b1);
      chk("ab_en", en0, 1'b0);
      chk("ab_rdy", rdy0, 1'b1);
      chk("ab_done", done0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk_int("ab_no_done", dn0 - base, 0);
      v0 = 1'b1; d0 = 8'hFF;
      send_frame(12'b0011_1111_1110, 10, 4, "fff");
      end_chk("fff_end");
      idle_chk("fff_idle");
      chk_int("fff_one_done", dn0 - base, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
